// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: WIDTH-bit Sklansky parallel-prefix adder with carry-in,
// carry-out and STAGES register ranks under a single valid/ready stall domain.
// Optional feature macro: PPA_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_prefix_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PPA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned L = $clog2(WIDTH);

  // Signals carried between prefix levels (and held by every inner rank)
  typedef struct packed {
    logic             vld;
    logic             ci;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pg;
  } lvl_t;

  // A rank sits after level round(k*(L+1)/STAGES), k=1..STAGES; level L+1 is the sum stage
  function automatic bit rank_after(input int lvl);
    int lv;
    int st;
    lv = int'(L) + 1;
    st = int'(STAGES);
    for (int k = 1; k <= st; k++) begin
      if ((2 * k * lv + st) / (2 * st) == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic en;

  // Global stall: every rank shifts together or holds together
  assign en = !out_valid || out_ready;

  for (genvar j = 0; j <= int'(L); j++) begin : g_lvl
    lvl_t x_out;
    lvl_t x_nxt;

    if (j == 0) begin : g_pre
      // Level 0: bitwise generate/propagate, cin folded into bit 0 (G[-1]=cin, P[-1]=0)
      always_comb begin
        x_out       = '0;
        x_out.vld   = in_valid;
        x_out.ci    = cin;
        x_out.p     = a ^ b;
        x_out.gg    = a & b;
        x_out.pg    = a ^ b;
        x_out.gg[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        x_out.pg[0] = 1'b0;
      end
    end else begin : g_pfx
      lvl_t             x_in;
      logic [WIDTH-1:0] gg_o;
      logic [WIDTH-1:0] pg_o;

      assign x_in = g_lvl[j-1].x_nxt;

      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (((i >> (j - 1)) % 2) == 1) begin : g_cell
          localparam int K = ((i >> (j - 1)) << (j - 1)) - 1;
          assign gg_o[i] = x_in.gg[i] | (x_in.pg[i] & x_in.gg[K]);
          assign pg_o[i] = x_in.pg[i] & x_in.pg[K];
        end else begin : g_pass
          assign gg_o[i] = x_in.gg[i];
          assign pg_o[i] = x_in.pg[i];
        end
      end

      // Sklansky level j: black cells on the upper half of each 2^j group
      always_comb begin
        x_out    = x_in;
        x_out.gg = gg_o;
        x_out.pg = pg_o;
      end
    end

    if (rank_after(j)) begin : g_rank
      lvl_t x_d;
      lvl_t x_q;

      // Rank input: shift on enable, otherwise hold
      always_comb begin
        x_d = x_q;
        if (en) x_d = x_out;
      end

      // Inner pipeline rank register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) x_q <= '0;
        else        x_q <= x_d;
      end

      assign x_nxt = x_q;
    end else begin : g_wire
      assign x_nxt = x_out;
    end
  end

  lvl_t             fin;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             vld_c;
  logic             ovf_c;
  logic             unused_pg;

  assign fin       = g_lvl[L].x_nxt;
  // Group propagates are all zero once cin has been folded in; nothing reads them here
  assign unused_pg = ^fin.pg;

  // Post-processing: sum[i] = p[i] ^ C[i-1] with C[-1] = cin
  always_comb begin
    sum_c  = fin.p ^ {fin.gg[WIDTH-2:0], fin.ci};
    cout_c = fin.gg[WIDTH-1];
    vld_c  = fin.vld;
    ovf_c  = fin.gg[WIDTH-1] ^ fin.gg[WIDTH-2];
  end

  if (STAGES == 0) begin : g_comb
    assign out_valid = vld_c;
    assign in_ready  = out_ready;
    assign sum       = sum_c;
    assign cout      = cout_c;
`ifdef PPA_OVF_EN
    assign ovf       = ovf_c;
`endif
  end else begin : g_out
    logic             vld_d;
    logic             vld_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             ovf_d;
    logic             ovf_q;

    // Last rank: capture result on enable, otherwise hold it stable
    always_comb begin
      vld_d  = vld_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      if (en) begin
        vld_d  = vld_c;
        sum_d  = sum_c;
        cout_d = cout_c;
        ovf_d  = ovf_c;
      end
    end

    // Output rank register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        sum_q  <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        vld_q  <= vld_d;
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end

    assign out_valid = vld_q;
    assign in_ready  = en;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef PPA_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
  end

endmodule
